// File: rtl/online_pkg.sv
// Shared encoding and sizing for the online multiplier sequencer and its
// downstream computation controller.
package online_pkg;

    localparam int CNT_W        = 9;
    localparam int DIGIT_W      = 7;
    localparam int DRAIN_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/online_sequencer.sv
// Master cycle counter and operation FSM for the online multiplier: walks
// cnt_master through N+1 digit cycles of four sub-cycles, drains, then pulses done.
module online_sequencer #(
    parameter int CNT_W        = online_pkg::CNT_W,
    parameter int DIGIT_W      = online_pkg::DIGIT_W,
    parameter int DRAIN_CYCLES = online_pkg::DRAIN_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DIGIT_W-1:0] num_digits,
    input  logic               enable_for_input,
    output logic [CNT_W-1:0]   cnt_master,
    output logic               busy,
    output logic               done,
    output logic               digit_req,
    output logic [DIGIT_W-1:0] digit_idx
);
    import online_pkg::*;

    // state | meaning
    // IDLE  | waiting for start, counter parked at 0
    // RUN   | cnt_master counting, digit requests issued
    // DRAIN | counter frozen at its last value while downstream writes land
    // DONE  | single completion cycle, counter cleared

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t         state, state_nx;
    logic [DIGIT_W-1:0] n_lat, n_nx;
    logic [DIGIT_W-1:0] idx_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic [CNT_W-1:0]   cnt_final;
    logic [DRAIN_W-1:0] drain_cnt, drain_nx;
    logic               req_nx;
    logic               busy_nx;
    logic               done_nx;

    // Last sub-cycle of digit iteration N; the counter stops here so it never wraps.
    assign cnt_final = CNT_W'({n_lat, 2'b11});

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_master;
        n_nx     = n_lat;
        idx_nx   = digit_idx;
        drain_nx = drain_cnt;
        req_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (start && !abort && (num_digits != '0)) begin
                    state_nx = ST_RUN;
                    n_nx     = num_digits;
                    idx_nx   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt_master == cnt_final) begin
                    state_nx = ST_DRAIN;
                    drain_nx = DRAIN_W'(DRAIN_CYCLES - 1);
                end else begin
                    cnt_nx = cnt_master + 1'b1;
                    // Excluding the final count keeps digit_req low throughout DRAIN.
                    if (enable_for_input && (cnt_master[1:0] == 2'b11) && (digit_idx < n_lat)) begin
                        req_nx = 1'b1;
                        idx_nx = digit_idx + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (drain_cnt == '0) begin
                    state_nx = ST_DONE;
                    cnt_nx   = '0;
                end else begin
                    drain_nx = drain_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
        busy_nx = (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
        done_nx = (state_nx == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt_master <= '0;
            n_lat      <= '0;
            digit_idx  <= '0;
            drain_cnt  <= '0;
            digit_req  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt_master <= cnt_nx;
            n_lat      <= n_nx;
            digit_idx  <= idx_nx;
            drain_cnt  <= drain_nx;
            digit_req  <= req_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

endmodule

// File: tb/tb_online_sequencer.sv
// Directed bench for online_sequencer: full operations checked cycle by cycle
// against hand-derived timing, plus abort, reset and ignored-start cases.
module tb_online_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [6:0] num_digits;
    logic       enable_for_input;
    logic [8:0] cnt_master;
    logic       busy;
    logic       done;
    logic       digit_req;
    logic [6:0] digit_idx;

    int n_assert = 0;
    int n_fail   = 0;

    online_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .num_digits       (num_digits),
        .enable_for_input (enable_for_input),
        .cnt_master       (cnt_master),
        .busy             (busy),
        .done             (done),
        .digit_req        (digit_req),
        .digit_idx        (digit_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " cnt"},  32'(cnt_master), 32'd0);
        check({tag, " busy"}, 32'(busy),       32'd0);
        check({tag, " done"}, 32'(done),       32'd0);
        check({tag, " req"},  32'(digit_req),  32'd0);
    endtask

    // Drive a one-cycle start from a negedge; returns at the next negedge.
    task automatic pulse_start(input int n, input logic with_abort);
        start      = 1'b1;
        abort      = with_abort;
        num_digits = 7'(n);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Full operation of N digits. Cycle k=0 is the first RUN cycle.
    // en_off: cycle in which enable_for_input is dropped (-1 none).
    // inj_k: cycle in which a stray start with N=9 is driven (-1 none).
    task automatic run_full(input string tag, input int n, input int en_off,
                            input int inj_k, input int exp_idx);
        int   fin;
        int   model_idx;
        logic trig;
        logic prev_trig;
        int   e_cnt;
        logic e_busy;
        logic e_done;
        fin       = 4 * n + 3;
        model_idx = 0;
        prev_trig = 1'b0;
        enable_for_input = 1'b1;
        pulse_start(n, 1'b0);
        for (int k = 0; k <= fin + 6; k++) begin
            if (k <= fin) begin
                e_cnt = k; e_busy = 1'b1; e_done = 1'b0;
            end else if (k <= fin + 4) begin
                e_cnt = fin; e_busy = 1'b1; e_done = 1'b0;
            end else if (k == fin + 5) begin
                e_cnt = 0; e_busy = 1'b0; e_done = 1'b1;
            end else begin
                e_cnt = 0; e_busy = 1'b0; e_done = 1'b0;
            end
            check($sformatf("%s k%0d cnt", tag, k),  32'(cnt_master), 32'(e_cnt));
            check($sformatf("%s k%0d busy", tag, k), 32'(busy),       32'(e_busy));
            check($sformatf("%s k%0d done", tag, k), 32'(done),       32'(e_done));
            check($sformatf("%s k%0d req", tag, k),  32'(digit_req),  32'(prev_trig));
            enable_for_input = (k != en_off);
            start            = (k == inj_k);
            if (k == inj_k) num_digits = 7'd9;
            // A request is raised on the edge closing a sub-cycle-3 cycle, never on the final count.
            trig = (k < fin) && enable_for_input && (k % 4 == 3) && (model_idx < n);
            if (trig) model_idx++;
            prev_trig = trig;
            @(posedge clk);
            @(negedge clk);
        end
        start            = 1'b0;
        enable_for_input = 1'b1;
        check({tag, " final idx"}, 32'(digit_idx), 32'(exp_idx));
    endtask

    // Start N, then at cycle `at` assert abort (use_rst=0) or rst (use_rst=1).
    task automatic run_cut(input string tag, input int n, input int at, input logic use_rst);
        int dones;
        pulse_start(n, 1'b0);
        for (int k = 0; k < at; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, " cnt at cut"}, 32'(cnt_master), 32'(at));
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        abort = 1'b0;
        check_idle({tag, " after"});
        if (use_rst) check({tag, " idx after rst"}, 32'(digit_idx), 32'd0);
        dones = 0;
        for (int k = 0; k < 4 * n + 12; k++) begin
            if (done || busy) dones++;
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, " no done/busy later"}, 32'(dones), 32'd0);
    endtask

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        num_digits       = 7'd0;
        enable_for_input = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset idx", 32'(digit_idx), 32'd0);
        rst = 1'b0;

        // First edge after release accepts start.
        run_full("n2", 2, -1, -1, 2);
        run_full("n3 en_off7", 3, 7, -1, 2);

        run_cut("abort n5", 5, 9, 1'b0);
        run_cut("rst n4", 4, 6, 1'b1);
        run_full("n1 after rst", 1, -1, -1, 1);

        pulse_start(0, 1'b0);
        check_idle("zero digits");
        @(posedge clk);
        @(negedge clk);
        check_idle("zero digits +1");

        pulse_start(3, 1'b1);
        check_idle("start+abort");
        @(posedge clk);
        @(negedge clk);
        check_idle("start+abort +1");

        run_full("n2 stray start", 2, -1, 5, 2);

        // Abort while idle does nothing and does not disturb the held index.
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort idle");
        check("abort idle idx", 32'(digit_idx), 32'd2);

        run_full("n127", 127, -1, -1, 127);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
